// File: rtl/rgb_fade_ctrl.sv
// rgb_fade_ctrl: sequences three RGB PWM channels from handshaked intensity updates; duties reach pwm_o only at period wraps.
// Define RGB_FADE_EN for tick-paced ramping toward targets; without it LOAD writes the active duty directly.
module rgb_fade_ctrl #(
    parameter int R        = 8,
    parameter int TICK_DIV = 1000,
    parameter int STEP     = 1
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic [R:0]           color_intencity_i,
    input  logic [2:0]           change_color_i,
    input  logic                 upd_valid_i,
    output logic                 upd_ready_o,
    output logic                 busy_o,
    output logic [3*(R+1)-1:0]   duty_o,
    output logic [2:0]           pwm_o
);
    typedef enum logic [1:0] {IDLE, LOAD, RAMP} state_t;
    localparam logic [R:0] FULL = {1'b1, {R{1'b0}}};

    state_t          state_q, state_d;
    logic [R:0]      hold_int_q, hold_int_d, clamped;
    logic [2:0]      hold_sel_q, hold_sel_d, pwm_q, pwm_d;
    logic [2:0][R:0] target_q, target_d, active_q, active_d, shadow_q, shadow_d;
    logic [R-1:0]    cnt_q, cnt_d;
    logic            accept;

    if (TICK_DIV < 2 || STEP < 1) begin : g_bad_cfg
        $error("rgb_fade_ctrl: TICK_DIV must be >= 2 and STEP >= 1");
    end

    assign upd_ready_o = state_q != LOAD;
    assign busy_o      = state_q != IDLE;
    assign accept      = upd_valid_i && upd_ready_o;
    assign clamped     = hold_int_q > FULL ? FULL : hold_int_q;
    assign duty_o      = active_q;
    assign pwm_o       = pwm_q;

`ifdef RGB_FADE_EN
    localparam int PW = $clog2(TICK_DIV);
    localparam logic signed [R+1:0] STEP_S = (R+2)'(STEP);

    logic [PW-1:0]       presc_q, presc_d;
    logic                tick;
    logic signed [R+1:0] diff [3];

    always_comb begin
        tick    = presc_q == PW'(TICK_DIV - 1);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    always_comb
        for (int k = 0; k < 3; k++)
            diff[k] = $signed({1'b0, target_q[k]}) - $signed({1'b0, active_q[k]});

    always_ff @(posedge clk_i or negedge arst_n_i)
        if (!arst_n_i) presc_q <= '0;
        else           presc_q <= presc_d;
`endif

    always_comb begin
        state_d    = state_q;
        hold_int_d = hold_int_q;
        hold_sel_d = hold_sel_q;
        target_d   = target_q;
        active_d   = active_q;
        if (accept) begin
            hold_int_d = color_intencity_i;
            hold_sel_d = change_color_i;
            state_d    = LOAD;
        end
        if (state_q == LOAD) begin
            for (int k = 0; k < 3; k++)
                if (hold_sel_q[k]) begin
                    target_d[k] = clamped;
`ifndef RGB_FADE_EN
                    active_d[k] = clamped;
`endif
                end
`ifdef RGB_FADE_EN
            state_d = (active_q != target_d) ? RAMP : IDLE;
`else
            state_d = IDLE;
`endif
        end
`ifdef RGB_FADE_EN
        // Step clamps to the remaining distance so a channel lands exactly on its target.
        if (state_q == RAMP && tick) begin
            for (int k = 0; k < 3; k++)
                active_d[k] = diff[k] >  STEP_S ? active_q[k] + STEP_S[R:0] :
                              diff[k] < -STEP_S ? active_q[k] - STEP_S[R:0] : target_q[k];
            if (!accept && active_d == target_q) state_d = IDLE;
        end
`endif
    end

    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        shadow_d = (&cnt_q) ? active_q : shadow_q;
        for (int k = 0; k < 3; k++) pwm_d[k] = {1'b0, cnt_q} < shadow_q[k];
    end

    always_ff @(posedge clk_i or negedge arst_n_i)
        if (!arst_n_i) begin
            state_q    <= IDLE;
            hold_int_q <= '0;
            hold_sel_q <= '0;
            target_q   <= '0;
            active_q   <= '0;
            shadow_q   <= '0;
            cnt_q      <= '0;
            pwm_q      <= '0;
        end else begin
            state_q    <= state_d;
            hold_int_q <= hold_int_d;
            hold_sel_q <= hold_sel_d;
            target_q   <= target_d;
            active_q   <= active_d;
            shadow_q   <= shadow_d;
            cnt_q      <= cnt_d;
            pwm_q      <= pwm_d;
        end
endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// tb_rgb_fade_ctrl: directed bench for rgb_fade_ctrl with R=8, TICK_DIV=4, STEP=10; covers both RGB_FADE_EN builds.
module tb_rgb_fade_ctrl;
    localparam int R = 8;

    logic               clk = 1'b0;
    logic               arst_n_i = 1'b0;
    logic [R:0]         intensity = '0;
    logic [2:0]         sel = '0;
    logic               upd_valid = 1'b0;
    logic               upd_ready, busy;
    logic [3*(R+1)-1:0] duty;
    logic [2:0]         pwm;
    int                 n_cmp = 0, n_err = 0;
    int                 seq[$], gaps[$];

    rgb_fade_ctrl #(.R(R), .TICK_DIV(4), .STEP(10)) dut (
        .clk_i(clk), .arst_n_i(arst_n_i), .color_intencity_i(intensity),
        .change_color_i(sel), .upd_valid_i(upd_valid), .upd_ready_o(upd_ready),
        .busy_o(busy), .duty_o(duty), .pwm_o(pwm)
    );

    always #5 clk = ~clk;

    function automatic string fmt(input int q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
        return s;
    endfunction

    // Call at a negedge; returns at the negedge of the LOAD cycle.
    task automatic send(input logic [R:0] v, input logic [2:0] s);
        bit r;
        int n = 0;
        upd_valid = 1'b1; intensity = v; sel = s;
        do begin r = upd_ready; @(posedge clk); n++; end while (!r && n < 20);
        #1 upd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int limit, output bit to);
        int n = 0;
        while (busy && n < limit) begin @(negedge clk); n++; end
        to = busy;
    endtask

    task automatic watch_r(output bit to);
        int last = int'(duty[8:0]);
        int n = 0, t_last = -1;
        seq.delete(); gaps.delete();
        while (busy && n < 400) begin
            @(negedge clk); n++;
            if (int'(duty[8:0]) != last) begin
                if (t_last >= 0) gaps.push_back(n - t_last);
                t_last = n; last = int'(duty[8:0]); seq.push_back(last);
            end
        end
        to = busy;
    endtask

    task automatic test_reset;
        arst_n_i = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (duty !== '0) begin n_err++; $display("FAIL reset_duty: got %h need 0", duty); end
        n_cmp++; if (pwm !== 3'b000) begin n_err++; $display("FAIL reset_pwm: got %b need 000", pwm); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b need 0", busy); end
        n_cmp++; if (upd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b need 1", upd_ready); end
        arst_n_i = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || upd_ready !== 1'b1 || duty !== '0)
            begin n_err++; $display("FAIL post_reset: busy=%b ready=%b duty=%h need 0 1 0", busy, upd_ready, duty); end
    endtask

`ifdef RGB_FADE_EN
    task automatic test_up_ramp;
        bit to;
        int bad = 0;
        send(9'd60, 3'b001);
        n_cmp++; if (upd_ready !== 1'b0 || busy !== 1'b1)
            begin n_err++; $display("FAIL up_load_flags: ready=%b busy=%b need 0 1", upd_ready, busy); end
        watch_r(to);
        n_cmp++; if (to || fmt(seq) != "10 20 30 40 50 60 ")
            begin n_err++; $display("FAIL up_ramp_seq: got '%s' timeout=%0b need '10 20 30 40 50 60 '", fmt(seq), to); end
        foreach (gaps[i]) if (gaps[i] != 4) bad++;
        n_cmp++; if (bad != 0 || gaps.size() != 5)
            begin n_err++; $display("FAIL up_ramp_gaps: got '%s' need five gaps of 4", fmt(gaps)); end
        n_cmp++; if (duty !== {9'd0, 9'd0, 9'd60})
            begin n_err++; $display("FAIL up_ramp_final: got %h need G=B=0 R=60", duty); end
    endtask

    task automatic test_down_ramp;
        bit to;
        send(9'd35, 3'b001);
        watch_r(to);
        n_cmp++; if (to || fmt(seq) != "50 40 35 ")
            begin n_err++; $display("FAIL down_ramp_seq: got '%s' need '50 40 35 '", fmt(seq)); end
        send(9'd0, 3'b001);
        watch_r(to);
        n_cmp++; if (to || fmt(seq) != "25 15 5 0 ")
            begin n_err++; $display("FAIL down_to_zero_seq: got '%s' need '25 15 5 0 '", fmt(seq)); end
    endtask

    task automatic test_retarget;
        bit to;
        int n = 0;
        send(9'd60, 3'b001);
        while (duty[8:0] != 9'd30 && n < 200) begin @(negedge clk); n++; end
        n_cmp++; if (duty[8:0] !== 9'd30) begin n_err++; $display("FAIL retarget_reach30: got %0d need 30", duty[8:0]); end
        send(9'd0, 3'b001);
        n_cmp++; if (upd_ready !== 1'b0) begin n_err++; $display("FAIL retarget_ready_low: got %b need 0", upd_ready); end
        @(negedge clk);
        n_cmp++; if (upd_ready !== 1'b1 || busy !== 1'b1)
            begin n_err++; $display("FAIL retarget_ready_back: ready=%b busy=%b need 1 1", upd_ready, busy); end
        watch_r(to);
        n_cmp++; if (to || fmt(seq) != "20 10 0 ")
            begin n_err++; $display("FAIL retarget_seq: got '%s' need '20 10 0 '", fmt(seq)); end
    endtask
`else
    task automatic test_direct_load;
        send(9'd60, 3'b001);
        n_cmp++; if (upd_ready !== 1'b0 || busy !== 1'b1)
            begin n_err++; $display("FAIL load_flags: ready=%b busy=%b need 0 1", upd_ready, busy); end
        n_cmp++; if (duty !== '0) begin n_err++; $display("FAIL load_duty_early: got %h need 0", duty); end
        @(negedge clk);
        n_cmp++; if (duty !== {9'd0, 9'd0, 9'd60})
            begin n_err++; $display("FAIL direct_duty: got %h need G=B=0 R=60", duty); end
        n_cmp++; if (upd_ready !== 1'b1 || busy !== 1'b0)
            begin n_err++; $display("FAIL direct_idle: ready=%b busy=%b need 1 0", upd_ready, busy); end
    endtask
`endif

    task automatic test_clamp;
        bit to;
        int bad = 0;
        send(9'd300, 3'b111);
        wait_idle(400, to);
        n_cmp++; if (to || duty !== {3{9'd256}})
            begin n_err++; $display("FAIL clamp_duty: got %h timeout=%0b need all 256", duty, to); end
        repeat (300) @(negedge clk);
        for (int i = 0; i < 256; i++) begin if (pwm !== 3'b111) bad++; @(negedge clk); end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL full_scale_pwm: %0d cycles not 111 need 0", bad); end
        send(9'd5, 3'b000);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL sel000_load: busy=%b need 1", busy); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || duty !== {3{9'd256}})
            begin n_err++; $display("FAIL sel000_nochange: busy=%b duty=%h need 0 all 256", busy, duty); end
        send(9'd0, 3'b111);
        wait_idle(400, to);
        repeat (300) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 256; i++) begin if (pwm !== 3'b000) bad++; @(negedge clk); end
        n_cmp++; if (to || duty !== '0 || bad != 0)
            begin n_err++; $display("FAIL zero_pwm: duty=%h bad=%0d timeout=%0b need 0 0 0", duty, bad, to); end
    endtask

    task automatic test_glitch;
        bit to, found = 1'b0;
        logic prev;
        int h0 = 0, h1 = 0;
        send(9'd128, 3'b111);
        wait_idle(400, to);
        repeat (600) @(negedge clk);
        prev = pwm[0];
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (pwm[0] && !prev) found = 1'b1;
            prev = pwm[0];
        end
        n_cmp++; if (to || !found) begin n_err++; $display("FAIL pwm_rise: found=%0b timeout=%0b need 1 0", found, to); end
        for (int i = 0; i < 512; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 30) begin upd_valid = 1'b1; intensity = 9'd64; sel = 3'b001; end
            if (i == 31) upd_valid = 1'b0;
            if (i < 256) h0 += int'(pwm[0]); else h1 += int'(pwm[0]);
        end
        n_cmp++; if (h0 != 128) begin n_err++; $display("FAIL glitch_old_period: high=%0d need 128", h0); end
        n_cmp++; if (h1 != 64) begin n_err++; $display("FAIL glitch_new_period: high=%0d need 64", h1); end
        n_cmp++; if (duty[8:0] !== 9'd64) begin n_err++; $display("FAIL glitch_duty: got %0d need 64", duty[8:0]); end
    endtask

    task automatic test_back_to_back;
        bit to;
        upd_valid = 1'b1; intensity = 9'd20; sel = 3'b001;
        n_cmp++; if (upd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_s0_ready: got %b need 1", upd_ready); end
        @(posedge clk); #1 intensity = 9'd40; sel = 3'b010;
        @(negedge clk);
        n_cmp++; if (upd_ready !== 1'b0 || busy !== 1'b1)
            begin n_err++; $display("FAIL b2b_s1: ready=%b busy=%b need 0 1", upd_ready, busy); end
        @(negedge clk);
        n_cmp++; if (upd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_s2_ready: got %b need 1", upd_ready); end
        @(posedge clk); #1 upd_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (upd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_s3_ready: got %b need 0", upd_ready); end
        wait_idle(400, to);
        n_cmp++; if (to || duty !== {9'd128, 9'd40, 9'd20})
            begin n_err++; $display("FAIL b2b_final: got %h timeout=%0b need B=128 G=40 R=20", duty, to); end
    endtask

    task automatic test_mid_reset;
        send(9'd200, 3'b111);
`ifdef RGB_FADE_EN
        repeat (10) @(negedge clk);
`endif
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_pre_busy: got %b need 1", busy); end
        #2 arst_n_i = 1'b0;
        #1;
        n_cmp++; if (duty !== '0 || pwm !== 3'b000)
            begin n_err++; $display("FAIL midrst_outputs: duty=%h pwm=%b need 0 000", duty, pwm); end
        n_cmp++; if (busy !== 1'b0 || upd_ready !== 1'b1)
            begin n_err++; $display("FAIL midrst_flags: busy=%b ready=%b need 0 1", busy, upd_ready); end
        @(negedge clk);
        arst_n_i = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (duty !== '0 || busy !== 1'b0)
            begin n_err++; $display("FAIL midrst_lost: duty=%h busy=%b need 0 0", duty, busy); end
    endtask

    initial begin
        test_reset();
`ifdef RGB_FADE_EN
        test_up_ramp();
        test_down_ramp();
        test_retarget();
`else
        test_direct_load();
`endif
        test_clamp();
        test_glitch();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rgb_fade_ctrl.md
# rgb_fade_ctrl

Controller that sequences the three-channel RGB PWM datapath from keyboard-decoded intensity updates. Accepts intensity/colour-select updates through a valid/ready handshake, holds a per-channel target, ramps each channel's active duty toward its target at a programmable rate, and drives the three PWM outputs. Duty changes reach the outputs only at PWM period boundaries, so the outputs never glitch.

## Interface
- `R`, 8: intensity width is R+1 bits; full scale 2^R (256).
- `TICK_DIV`, 1000: clk_i cycles per ramp tick; must be ≥2.
- `STEP`, 1: maximum duty change per channel per tick; must be ≥1.
- `clk_i`  in  1  system clock. One clock domain.
- `arst_n_i`  in  1  reset, asynchronous, active-low.
- `color_intencity_i`  in  R+1  requested intensity. Synchronous to clk_i.
- `change_color_i`  in  3  channel select; bit0=R, bit1=G, bit2=B.
- `upd_valid_i`  in  1  update request.
- `upd_ready_o`  out  1  update can be accepted.
- `busy_o`  out  1  load or ramp in progress.
- `duty_o`  out  3*(R+1)  active duties {B,G,R}.
- `pwm_o`  out  3  PWM outputs {B,G,R}.

## Operation
- Reset values: state IDLE, all targets, active duties, shadow duties and counters 0, `pwm_o`=0, `duty_o`=0, `upd_ready_o`=1, `busy_o`=0.
- Accept: `upd_valid_i && upd_ready_o` at a rising edge. Intensity and select are captured into a holding register, and state goes to LOAD.
- FSM states: IDLE, LOAD, RAMP. `upd_ready_o`=1 in IDLE and RAMP, 0 in LOAD. `busy_o`=1 in LOAD and RAMP.
- LOAD lasts one cycle. Its actions:
  - Clamp intensity to 2^R (e.g. 300→256).
  - Write the clamped value to the target of every channel whose select bit is set. A select of 000 is accepted and changes nothing.
  - Next state is RAMP if any active duty ≠ its target, else IDLE.
- Retargeting mid-ramp is legal: an accept in RAMP goes to LOAD and then returns to RAMP. Active duties are untouched by LOAD.
- Prescaler:
  - Free-running 0..TICK_DIV-1.
  - `tick`=1 for the cycle where it equals TICK_DIV-1.
  - Reset to 0 only by `arst_n_i`.
- RAMP step: on each tick cycle, every channel with active ≠ target moves toward its target by min(STEP, |target−active|). It never overshoots.
- RAMP exit: go to IDLE at the edge where the step leaves all active duties equal to their targets.
- A tick that falls in LOAD or IDLE is discarded.
- PWM counter: R bits, free-running 0..2^R−1, wraps to 0.
- Shadow duties: copied from active duties at the edge where the counter equals 2^R−1.
- PWM output: `pwm_o[k]` is registered and equals (counter < shadow[k]). Shadow 0 gives constant 0; shadow 2^R gives constant 1.
- Width rules: differences are computed R+2 bits signed; no wrap-around.

## Timing
- Edge N accepts the update. State is LOAD during cycle N..N+1, and targets update at edge N+1.
- `upd_ready_o` is low for exactly one cycle per accept. Back-to-back updates are therefore accepted every 2 cycles.
- `duty_o` changes only on tick edges (or at the LOAD edge without `RGB_FADE_EN`).
- Active duty to `pwm_o`: the shadow is captured at the next period wrap, and `pwm_o` lags the counter comparison by 1 cycle.
- If `arst_n_i` is asserted mid-ramp or mid-load, everything returns to reset values immediately. A pending update is lost.

## Configuration
- `RGB_FADE_EN` defined: fade behaviour as above; the prescaler and STEP logic are present.
- `RGB_FADE_EN` undefined:
  - LOAD writes the clamped value to both target and active duty of the selected channels.
  - LOAD always returns to IDLE; RAMP is unreachable.
  - Prescaler and STEP logic are removed; TICK_DIV and STEP are ignored.
  - The shadow/period-boundary rule still applies.

## Test plan
Bench parameters: R=8, TICK_DIV=4, STEP=10.
- Reset check: assert `arst_n_i` low mid-operation → all of the following immediately: `pwm_o`=0, `duty_o`=0, `busy_o`=0, `upd_ready_o`=1.
- Up-ramp: update intensity 60, select 001 → R active duty steps 10,20,…,60 on consecutive ticks (every 4 cycles), then IDLE. G and B stay 0.
- Down-ramp without overshoot: from R=60, update intensity 35, select 001 → R goes 50,40,35, then IDLE.
- Clamp and multi-select: update intensity 300, select 111 → all three targets 256. After ramp, `pwm_o`=111 constantly.
- Mid-ramp retarget: during the up-ramp to 60 at duty 30, update intensity 0 → `upd_ready_o` low for 1 cycle, then duty 20,10,0.
- PWM glitch-free and no-fade check:
  - Change duty mid-period: `pwm_o` high time changes only in the period after the wrap. Duty 128 gives 128 high cycles of 256.
  - Without `RGB_FADE_EN`: `duty_o` jumps directly to the target one edge after the accept.
